pipeline_ctrl: RTL and testbench

Hazard and stall scheduler for the 5-stage MIPS pipeline. It drives the valid (advance-enable) and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles three events: load-use hazards, control redirects resolved in EX, and multi-cycle data-memory/IO accesses with a timeout. It also keeps saturating stall and flush event counters for debug readout.

---
 rtl/pipeline_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/stall scheduler for the 5-stage pipeline: load-use stalls, EX redirects,
// multi-cycle memory waits with timeout, and saturating stall/flush counters.
module pipeline_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_MemtoReg,
    input  logic [4:0]       ex_wr_addr,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_valid,
    output logic             idex_valid,
    output logic             exmem_valid,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     cur, nxt;
    logic [7:0] wait_cnt;
    logic       hz;
    logic       wait_done;
    logic       freeze;
    logic       enter_wait;
    logic       forced_exit;
    logic       redirect_taken;

    assign hz = ex_MemtoReg && (ex_wr_addr != 5'd0) &&
                ((id_uses_rs && (id_rs_addr == ex_wr_addr)) ||
                 (id_uses_rt && (id_rt_addr == ex_wr_addr)));

    assign state = cur;

    always_comb begin
        pc_en          = 1'b1;
        ifid_valid     = 1'b1;
        idex_valid     = 1'b1;
        exmem_valid    = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        memwb_flush    = 1'b0;
        nxt            = RUN;
        enter_wait     = 1'b0;
        redirect_taken = 1'b0;
        wait_done      = mem_ack || (wait_cnt == WAIT_LAST);
        // In MEMWAIT only the exit condition releases the pipe; elsewhere a new
        // unacknowledged request freezes it. The release cycle falls through to
        // the redirect / load-use rules like a RUN cycle.
        freeze         = (cur == MEMWAIT) ? !wait_done : (mem_req && !mem_ack);
        forced_exit    = (cur == MEMWAIT) && !mem_ack && (wait_cnt == WAIT_LAST);

        if (freeze) begin
            pc_en       = 1'b0;
            ifid_valid  = 1'b0;
            idex_valid  = 1'b0;
            exmem_valid = 1'b0;
            memwb_flush = 1'b1;
            nxt         = MEMWAIT;
            enter_wait  = (cur != MEMWAIT);
        end else if (ex_redirect) begin
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            redirect_taken = 1'b1;
        end else if (hz && (cur != LDSTALL)) begin
            pc_en      = 1'b0;
            ifid_valid = 1'b0;
            idex_flush = 1'b1;
            nxt        = LDSTALL;
        end

        if (!reset) begin
            pc_en          = 1'b0;
            ifid_valid     = 1'b0;
            idex_valid     = 1'b0;
            exmem_valid    = 1'b0;
            ifid_flush     = 1'b0;
            idex_flush     = 1'b0;
            memwb_flush    = 1'b0;
            redirect_taken = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur         <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            cur <= nxt;
            if (enter_wait) begin
                wait_cnt <= '0;
            end else if (cur == MEMWAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (forced_exit) begin
                mem_timeout <= 1'b1;
            end
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect_taken && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: per-cycle expected control vectors are queued
// at drive time and checked half a cycle later against the DUT outputs.
module tb_pipeline_ctrl;

    localparam int unsigned CNT_W = 4;

    // {pc_en, ifid_valid, idex_valid, exmem_valid, ifid_flush, idex_flush, memwb_flush}
    localparam logic [6:0] NORM   = 7'b1111_000;
    localparam logic [6:0] STALL  = 7'b0011_010;
    localparam logic [6:0] REDIR  = 7'b1111_110;
    localparam logic [6:0] FREEZE = 7'b0000_001;
    localparam logic [6:0] RSTV   = 7'b0000_000;
    localparam logic [1:0] S_RUN = 2'd0, S_LD = 2'd1, S_MW = 2'd2;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs_addr, id_rt_addr, ex_wr_addr;
    logic             id_uses_rs, id_uses_rt, ex_MemtoReg, ex_redirect, mem_req, mem_ack;
    logic             pc_en, ifid_valid, idex_valid, exmem_valid;
    logic             ifid_flush, idex_flush, memwb_flush, mem_timeout;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    typedef struct {
        logic [6:0]       ctl;
        logic [1:0]       st;
        logic             to;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
        string            tag;
    } exp_t;

    exp_t             sb[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic             exp_to   = 1'b0;
    logic [CNT_W-1:0] exp_sc   = '0;
    logic [CNT_W-1:0] exp_fc   = '0;

    pipeline_ctrl #(.MEM_WAIT_MAX(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_MemtoReg(ex_MemtoReg), .ex_wr_addr(ex_wr_addr),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .ifid_valid(ifid_valid), .idex_valid(idex_valid),
        .exmem_valid(exmem_valid), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_flush(memwb_flush), .state(state), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic ml, input logic [4:0] wa,
                         input logic rd, input logic mq, input logic ma);
        id_rs_addr = rs; id_rt_addr = rt; id_uses_rs = urs; id_uses_rt = urt;
        ex_MemtoReg = ml; ex_wr_addr = wa; ex_redirect = rd; mem_req = mq; mem_ack = ma;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_one();
        exp_t       e;
        logic [6:0] act;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e   = sb.pop_front();
        act = {pc_en, ifid_valid, idex_valid, exmem_valid, ifid_flush, idex_flush, memwb_flush};
        n_checks++;
        assert (act === e.ctl) else begin
            n_fail++; $error("FAIL %s ctl: got %b expected %b", e.tag, act, e.ctl);
        end
        n_checks++;
        assert (state === e.st) else begin
            n_fail++; $error("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
        end
        n_checks++;
        assert (mem_timeout === e.to) else begin
            n_fail++; $error("FAIL %s mem_timeout: got %b expected %b", e.tag, mem_timeout, e.to);
        end
        n_checks++;
        assert (stall_cnt === e.sc) else begin
            n_fail++; $error("FAIL %s stall_cnt: got %0d expected %0d", e.tag, stall_cnt, e.sc);
        end
        n_checks++;
        assert (flush_cnt === e.fc) else begin
            n_fail++; $error("FAIL %s flush_cnt: got %0d expected %0d", e.tag, flush_cnt, e.fc);
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step(input logic [6:0] ctl, input logic [1:0] st, input string tag);
        exp_t e;
        if (!reset) begin
            exp_sc = '0; exp_fc = '0; exp_to = 1'b0;
        end
        e.ctl = ctl; e.st = st; e.to = exp_to; e.sc = exp_sc; e.fc = exp_fc; e.tag = tag;
        sb.push_back(e);
        if (reset) begin
            if (!ctl[6] && (exp_sc != '1)) exp_sc = exp_sc + 1'b1;
            if (ctl[2] && (exp_fc != '1)) exp_fc = exp_fc + 1'b1;
        end
        @(negedge clk);
        check_one();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        @(posedge clk);
        #1;
        step(RSTV, S_RUN, "reset_a");
        step(RSTV, S_RUN, "reset_b");
        reset = 1'b1;
        step(NORM, S_RUN, "idle");

        // load-use on rs, then one LDSTALL cycle, then back to RUN
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        step(STALL, S_RUN, "lu_rs");
        idle();
        step(NORM, S_LD, "lu_ldstall");
        step(NORM, S_RUN, "lu_back");
        drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(NORM, S_RUN, "lu_r0");
        // load-use on rt, held into LDSTALL where it is not re-evaluated
        drive(5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        step(STALL, S_RUN, "lu_rt");
        step(NORM, S_LD, "lu_held");
        drive(5'd1, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        step(NORM, S_RUN, "no_use_rt");
        drive(5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        step(NORM, S_RUN, "not_load");

        // redirect over a hazard, and a redirect during LDSTALL
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        step(REDIR, S_RUN, "redir_hz");
        idle();
        step(NORM, S_RUN, "after_redir");
        drive(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        step(STALL, S_RUN, "lu_pre_redir");
        drive(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        step(REDIR, S_LD, "redir_ld");
        idle();
        step(NORM, S_RUN, "redir_ld_back");

        // request acknowledged in the same cycle: no wait
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        step(NORM, S_RUN, "req_ack");

        // 4-cycle memory wait released on the ack cycle
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(FREEZE, S_RUN, "mw_enter");
        idle();
        for (int i = 0; i < 3; i++) step(FREEZE, S_MW, "mw_wait");
        mem_ack = 1'b1;
        step(NORM, S_MW, "mw_ack");
        idle();
        step(NORM, S_RUN, "mw_done");

        // request wins over redirect; redirect/hz ignored while frozen; redirect on ack
        drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        step(FREEZE, S_RUN, "req_over_redir");
        drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        step(FREEZE, S_MW, "mw_ign_redir");
        mem_ack = 1'b1;
        step(REDIR, S_MW, "mw_ack_redir");
        idle();
        step(NORM, S_RUN, "mw_redir_done");

        // ack exit with a hazard goes to LDSTALL; request from LDSTALL freezes
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(FREEZE, S_RUN, "mw2_enter");
        drive(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1);
        step(STALL, S_MW, "mw2_ack_hz");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(FREEZE, S_LD, "ld_req");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step(NORM, S_MW, "ld_req_ack");
        idle();
        step(NORM, S_RUN, "ld_req_done");

        // timeout: forced exit on the 4th MEMWAIT cycle, sticky flag
        mem_req = 1'b1;
        step(FREEZE, S_RUN, "to_enter");
        idle();
        for (int i = 0; i < 3; i++) step(FREEZE, S_MW, "to_wait");
        step(NORM, S_MW, "to_exit");
        exp_to = 1'b1;
        step(NORM, S_RUN, "to_set");
        mem_req = 1'b1;
        mem_ack = 1'b1;
        step(NORM, S_RUN, "to_sticky");
        idle();
        step(NORM, S_RUN, "to_sticky2");

        // counter saturation
        drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(STALL, S_RUN, "sat_stall");
            step(NORM, S_LD, "sat_ld");
        end
        n_checks++;
        assert (stall_cnt === 4'hF) else begin
            n_fail++; $error("FAIL stall_sat: got %0d expected 15", stall_cnt);
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) step(REDIR, S_RUN, "sat_redir");
        n_checks++;
        assert (flush_cnt === 4'hF) else begin
            n_fail++; $error("FAIL flush_sat: got %0d expected 15", flush_cnt);
        end

        // reset asserted in the 2nd wait cycle aborts to RUN immediately
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(FREEZE, S_RUN, "rst_enter");
        idle();
        step(FREEZE, S_MW, "rst_wait1");
        reset = 1'b0;
        step(RSTV, S_RUN, "rst_mid");
        step(RSTV, S_RUN, "rst_hold");
        reset = 1'b1;
        step(NORM, S_RUN, "rst_release");
        step(NORM, S_RUN, "rst_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
